// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and feeds the ALU control decoder with a mode and a funct-or-opcode selector.
module multicycle_control #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [1:0]     alu_op,
  output logic [OPW-1:0] alu_sel,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     pc_source,
  output logic           illegal,
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] FN_SUB   = 6'b100010;

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] fn_q;

  function automatic logic funct_legal(input logic [OPW-1:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100110, 6'b101010: funct_legal = 1'b1;
      default:                         funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_itype(input logic [OPW-1:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: is_itype = 1'b1;
      default:                                    is_itype = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == TRAP) illegal <= 1'b1;
    end
  end

  // Snapshot of IR fields taken in DECODE; later states decode from this copy.
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      op_q <= opcode;
      fn_q <= funct;
    end
  end

  always_comb begin
    state_nxt     = state;
    alu_op        = 2'b00;
    alu_sel       = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Gated by rst_n so no write strobe appears while reset is held.
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)                    state_nxt = EXEC_R;
        else if (is_itype(opcode))                 state_nxt = EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW) state_nxt = MEM_ADDR;
        else if (opcode == OP_BEQ)                 state_nxt = BRANCH;
        else if (opcode == OP_J)                   state_nxt = JUMP;
        else                                       state_nxt = TRAP;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_sel   = fn_q;
        state_nxt = funct_legal(fn_q) ? ALU_WB : TRAP;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op_q == OP_SLTI) begin
          alu_op = 2'b01;
        end else if (op_q != OP_ADDI) begin
          alu_op  = 2'b11;
          alu_sel = op_q;
        end
        state_nxt = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_RTYPE);
        state_nxt = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b10;
        alu_sel       = FN_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_nxt     = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks with inline checks.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [1:0] alu_op;
  logic [5:0] alu_sel;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       illegal;
  logic [3:0] state_o;
  logic [5:0] en;

  int total = 0;
  int bad = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_sel(alu_sel),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign en = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    opcode = 6'b000000; funct = 6'b100000;
    rst_n = 1'b0;
    #1;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL rst_state got %0d want 0", state_o); end
    total++; if (mem_read !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0) begin bad++; $display("FAIL rst_outs got rd=%b pcw=%b irw=%b want 1 0 0", mem_read, pc_write, ir_write); end
    do_reset();
    tick(); tick();
    total++; if (state_o !== 4'd2) begin bad++; $display("FAIL rst_pre_exec got %0d want 2", state_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (state_o !== 4'd0 || illegal !== 1'b0 || reg_write !== 1'b0) begin bad++; $display("FAIL rst_async got st=%0d ill=%b rw=%b want 0 0 0", state_o, illegal, reg_write); end
    #2 rst_n = 1'b1;
    tick();
    total++; if (state_o !== 4'd1) begin bad++; $display("FAIL rst_release got %0d want 1", state_o); end
    do_reset();
    total++; if (state_o !== 4'd0 || mem_read !== 1'b1) begin bad++; $display("FAIL rst_fetch got st=%0d rd=%b want 0 1", state_o, mem_read); end
  endtask

  task automatic test_rtype();
    do_reset();
    opcode = 6'b000000; funct = 6'b100110; mem_ready = 1'b1;
    #1;
    total++; if (ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01) begin bad++; $display("FAIL r_fetch got irw=%b pcw=%b srcb=%b want 1 1 01", ir_write, pc_write, alu_src_b); end
    tick();
    total++; if (state_o !== 4'd1 || alu_src_b !== 2'b11) begin bad++; $display("FAIL r_decode got st=%0d srcb=%b want 1 11", state_o, alu_src_b); end
    tick();
    total++; if (state_o !== 4'd2 || alu_op !== 2'b10 || alu_sel !== 6'b100110 || alu_src_a !== 1'b1) begin bad++; $display("FAIL r_exec got st=%0d op=%b sel=%b a=%b want 2 10 100110 1", state_o, alu_op, alu_sel, alu_src_a); end
    tick();
    total++; if (state_o !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin bad++; $display("FAIL r_wb got st=%0d rw=%b rd=%b m2r=%b want 8 1 1 0", state_o, reg_write, reg_dst, mem_to_reg); end
    tick();
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL r_latency got %0d want 0", state_o); end
  endtask

  task automatic test_itype();
    do_reset();
    opcode = 6'b001101; mem_ready = 1'b1;
    tick(); tick();
    total++; if (state_o !== 4'd3 || alu_op !== 2'b11 || alu_sel !== 6'b001101 || alu_src_b !== 2'b10) begin bad++; $display("FAIL ori_exec got st=%0d op=%b sel=%b b=%b want 3 11 001101 10", state_o, alu_op, alu_sel, alu_src_b); end
    tick();
    total++; if (state_o !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin bad++; $display("FAIL ori_wb got st=%0d rw=%b rd=%b want 8 1 0", state_o, reg_write, reg_dst); end
    do_reset();
    opcode = 6'b001010;
    tick(); tick();
    total++; if (state_o !== 4'd3 || alu_op !== 2'b01 || alu_sel !== 6'b000000) begin bad++; $display("FAIL slti_exec got st=%0d op=%b sel=%b want 3 01 000000", state_o, alu_op, alu_sel); end
  endtask

  task automatic test_lw_stall();
    int cyc;
    do_reset();
    opcode = 6'b100011; mem_ready = 1'b1;
    cyc = 0;
    tick(); cyc++; tick(); cyc++;
    total++; if (state_o !== 4'd4 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin bad++; $display("FAIL lw_addr got st=%0d b=%b op=%b want 4 10 00", state_o, alu_src_b, alu_op); end
    tick(); cyc++;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (state_o !== 4'd5 || mem_read !== 1'b1 || i_or_d !== 1'b1) begin bad++; $display("FAIL lw_stall%0d got st=%0d rd=%b iod=%b want 5 1 1", i, state_o, mem_read, i_or_d); end
      if (i == 2) mem_ready = 1'b1;
      tick(); cyc++;
    end
    total++; if (state_o !== 4'd6 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin bad++; $display("FAIL lw_wb got st=%0d m2r=%b rw=%b rd=%b want 6 1 1 0", state_o, mem_to_reg, reg_write, reg_dst); end
    tick(); cyc++;
    total++; if (state_o !== 4'd0 || cyc !== 7) begin bad++; $display("FAIL lw_latency got st=%0d cyc=%0d want 0 7", state_o, cyc); end
  endtask

  task automatic test_sw_stall();
    do_reset();
    opcode = 6'b101011; mem_ready = 1'b0;
    #1;
    total++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL fetch_wait got irw=%b pcw=%b rd=%b want 0 0 1", ir_write, pc_write, mem_read); end
    tick();
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL fetch_hold got %0d want 0", state_o); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    total++; if (state_o !== 4'd7 || mem_write !== 1'b1 || i_or_d !== 1'b1) begin bad++; $display("FAIL sw_wait got st=%0d wr=%b iod=%b want 7 1 1", state_o, mem_write, i_or_d); end
    tick();
    mem_ready = 1'b1;
    #1;
    total++; if (state_o !== 4'd7 || mem_write !== 1'b1) begin bad++; $display("FAIL sw_hold got st=%0d wr=%b want 7 1", state_o, mem_write); end
    tick();
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL sw_done got %0d want 0", state_o); end
  endtask

  task automatic test_branch_jump();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      opcode = 6'b000100; zero = z[0]; mem_ready = 1'b1;
      tick(); tick();
      total++; if (state_o !== 4'd9 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_sel !== 6'b100010 || alu_op !== 2'b10 || pc_write !== 1'b0) begin bad++; $display("FAIL beq_z%0d got st=%0d pwc=%b src=%b sel=%b op=%b pcw=%b want 9 1 01 100010 10 0", z, state_o, pc_write_cond, pc_source, alu_sel, alu_op, pc_write); end
      tick();
      total++; if (state_o !== 4'd0) begin bad++; $display("FAIL beq_lat%0d got %0d want 0", z, state_o); end
    end
    do_reset();
    opcode = 6'b000010;
    tick(); tick();
    total++; if (state_o !== 4'd10 || pc_write !== 1'b1 || pc_source !== 2'b10) begin bad++; $display("FAIL jump got st=%0d pcw=%b src=%b want 10 1 10", state_o, pc_write, pc_source); end
    tick();
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL jump_lat got %0d want 0", state_o); end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    total++; if (state_o !== 4'd1 || illegal !== 1'b0) begin bad++; $display("FAIL ill_decode got st=%0d ill=%b want 1 0", state_o, illegal); end
    tick();
    for (int i = 0; i < 20; i++) begin
      total++; if (state_o !== 4'd11 || illegal !== 1'b1 || en !== 6'b0 || i_or_d !== 1'b0) begin bad++; $display("FAIL trap_hold%0d got st=%0d ill=%b en=%b want 11 1 000000", i, state_o, illegal, en); end
      tick();
    end
    do_reset();
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got %b want 0", illegal); end
    opcode = 6'b000000; funct = 6'b000111;
    tick(); tick(); tick();
    total++; if (state_o !== 4'd11 || illegal !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("FAIL bad_funct got st=%0d ill=%b rw=%b want 11 1 0", state_o, illegal, reg_write); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_stall();
    test_sw_stall();
    test_branch_jump();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
